// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the MIPS data-memory controller: access sizes and FSM states.
package mips_cpu_pkg;

  // op_size encodings presented by the execute stage
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_WORD_UA = 2'b11;  // lwl/lwr: any address, loads only

  // Controller states; exposed on dbg_state_o for checkers
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/mips_cpu_dmem_lanes.sv
// Combinational lane steering: byte enables, replicated store data and the
// misalignment decision for one load/store request.
module mips_cpu_dmem_lanes
  import mips_cpu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        is_store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rt_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  // Loads always read the full word; the merge stage picks the bytes it needs.
  always_comb begin
    byteen_o     = 4'b1111;
    wdata_o      = rt_i;
    misaligned_o = 1'b0;
    if (is_store_i) begin
      case (size_i)
        SIZE_BYTE: begin
          byteen_o = 4'b0001 << addr_lo_i;
          wdata_o  = {4{rt_i[7:0]}};
        end
        SIZE_HALF: begin
          byteen_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o      = {2{rt_i[15:0]}};
          misaligned_o = addr_lo_i[0];
        end
        SIZE_WORD: begin
          misaligned_o = |addr_lo_i;
        end
        default: begin
          // unaligned word form exists for loads only
          misaligned_o = 1'b1;
        end
      endcase
    end else begin
      case (size_i)
        SIZE_HALF: misaligned_o = addr_lo_i[0];
        SIZE_WORD: misaligned_o = |addr_lo_i;
        default:   misaligned_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mips_cpu_dmem_ctrl.sv
// Data-memory access controller: accepts one load/store from execute, runs a
// single bus access with waitrequest handling and timeout, and returns the raw
// load word to the merge stage.
//
// Bus handshake: in ACCESS the strobe, address, byteenable and writedata are
// held constant; the access completes in the first ACCESS cycle where
// data_waitrequest=0, and data_readdata is taken in that same cycle.
module mips_cpu_dmem_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_store,
  input  logic [1:0]  op_size,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic [1:0]  load_addr_lo,
  output logic        load_valid,
  output logic        align_err,
  output logic        bus_timeout,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_byteenable,
  output logic [31:0] data_writedata,
  input  logic        data_waitrequest,
  input  logic [31:0] data_readdata,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  dmem_state_e   state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          is_store_q, is_store_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [1:0]    load_lo_q, load_lo_d;
  logic          align_err_q, align_err_d;
  logic          timeout_q, timeout_d;

  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic          lane_misaligned;
  logic          accept;

  mips_cpu_dmem_lanes u_lanes (
    .size_i       (op_size),
    .is_store_i   (op_is_store),
    .addr_lo_i    (op_addr[1:0]),
    .rt_i         (op_wdata),
    .byteen_o     (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_misaligned)
  );

  assign accept = (state_q == IDLE) && op_valid && !lane_misaligned;

  // Next-state logic: accept in IDLE, wait/complete/abort in ACCESS, one DONE cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    is_store_d  = is_store_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    load_data_d = load_data_q;
    load_lo_d   = load_lo_q;
    align_err_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (lane_misaligned) begin
            align_err_d = 1'b1;
          end else begin
            state_d    = ACCESS;
            addr_d     = op_addr;
            is_store_d = op_is_store;
            be_d       = lane_be;
            wdata_d    = lane_wdata;
            wait_cnt_d = '0;
          end
        end
      end
      ACCESS: begin
        if (data_waitrequest) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            // TIMEOUT-th wait cycle: give up, keep the previous load result
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end else begin
          if (!is_store_q) begin
            load_data_d = data_readdata;
            load_lo_d   = addr_q[1:0];
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset discards any access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      is_store_q  <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      load_data_q <= '0;
      load_lo_q   <= '0;
      align_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      is_store_q  <= is_store_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      load_data_q <= load_data_d;
      load_lo_q   <= load_lo_d;
      align_err_q <= align_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall           = accept || (state_q == ACCESS);
  assign data_read       = (state_q == ACCESS) && !is_store_q;
  assign data_write      = (state_q == ACCESS) && is_store_q;
  assign data_byteenable = (state_q == ACCESS) ? be_q : 4'b0000;
  assign data_address    = {addr_q[31:2], 2'b00};
  assign data_writedata  = wdata_q;
  assign load_data       = load_data_q;
  assign load_addr_lo    = load_lo_q;
  assign load_valid      = (state_q == DONE) && !is_store_q;
  assign align_err       = align_err_q;
  assign bus_timeout     = timeout_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/mips_cpu_dmem_ctrl.md
MIPS_CPU_DMEM_CTRL -- requirements
Module: mips_cpu_dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning the maximum number of cycles data_waitrequest may hold an access before it is aborted.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 op_valid  input  1  execute stage presents a load or store this cycle.
REQ-005 op_is_store  input  1  1 = store, 0 = load.
REQ-006 op_size  input  2  00 byte, 01 half, 10 word aligned, 11 word unaligned (lwl/lwr, loads only).
REQ-007 op_addr  input  32  effective byte address.
REQ-008 op_wdata  input  32  rt value for stores.
REQ-009 stall  output  1  freezes the pipeline while an access is outstanding.
REQ-010 load_data  output  32  raw word captured from data_readdata; feeds the load-merge stage.
REQ-011 load_addr_lo  output  2  op_addr[1:0] of the completed load.
REQ-012 load_valid  output  1  one-cycle pulse: load_data and load_addr_lo are valid.
REQ-013 align_err  output  1  one-cycle pulse: the op was rejected as misaligned.
REQ-014 bus_timeout  output  1  one-cycle pulse: the access was aborted after TIMEOUT wait cycles.
REQ-015 data_address  output  32  {op_addr[31:2], 2'b00}.
REQ-016 data_read / data_write  output  1 each  bus strobes; never both high.
REQ-017 data_byteenable  output  4  bit i qualifies data_writedata[8i+7:8i].
REQ-018 data_writedata  output  32  store data with lanes replicated.
REQ-019 data_waitrequest  input  1  memory not ready; strobes and address must be held.
REQ-020 data_readdata  input  32  read data, valid in the cycle that data_read=1 and data_waitrequest=0.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-022 IDLE, op_valid=1, op aligned: latch address, data, size and direction; go to ACCESS.
REQ-023 Alignment rules: a half access requires addr[0]=0; a word-aligned access requires addr[1:0]=00; op_size 11 accepts any address for loads; op_size 11 with a store is misaligned.
REQ-024 IDLE, op_valid=1, op misaligned: no bus strobe; align_err=1 in the next cycle only; remain in IDLE.
REQ-025 ACCESS: assert data_read or data_write from the latched values, held stable while data_waitrequest=1.
REQ-026 ACCESS with data_waitrequest=0: a load captures data_readdata into load_data; go to DONE.
REQ-027 DONE: load_valid=1 for loads only; return to IDLE unconditionally.
REQ-028 stall = (IDLE && op_valid && aligned) || ACCESS; stall=0 in DONE.
REQ-029 Zero-wait latency: op accepted in cycle N, strobe in cycle N+1, load_valid in cycle N+2, for two stall cycles in total.
REQ-030 Loads SHALL drive data_byteenable=1111.
REQ-031 sb SHALL drive data_byteenable=1<<addr[1:0] and data_writedata={4{rt[7:0]}}.
REQ-032 sh SHALL drive data_byteenable 0011 when addr[1]=0 and 1100 when addr[1]=1, with data_writedata={2{rt[15:0]}}.
REQ-033 sw SHALL drive data_byteenable=1111 and data_writedata=rt.
REQ-034 A wait counter SHALL clear on entry to ACCESS and increment per cycle with data_waitrequest=1.
REQ-035 When the wait counter reaches TIMEOUT: drop the strobes, pulse bus_timeout, return to IDLE, leave load_data unchanged, and do not pulse load_valid.
REQ-036 load_data and load_addr_lo SHALL hold their values until the next completed load.
REQ-037 op_valid SHALL be ignored outside IDLE; the held request is never replaced mid-access.

Reset
REQ-038 While reset=0 at a clk edge: state goes to IDLE; stall, strobes, load_valid, align_err and bus_timeout go to 0; data_byteenable goes to 0000; load_data and data_address go to 0; the wait counter goes to 0.
REQ-039 Reset asserted in ACCESS SHALL drop the strobes at that edge and discard the access.

Structure
REQ-040 Package mips_cpu_pkg SHALL hold the op_size encoding constants and the FSM state enum.
REQ-041 A combinational sub-module mips_cpu_dmem_lanes SHALL compute byteenable, replicated writedata and the misalignment flag.

Verification
REQ-042 lw at 0x1000, waitrequest=0, readdata=0xAABBCCDD -> stall high for 2 cycles, load_valid at N+2, load_data=0xAABBCCDD, load_addr_lo=0.
REQ-043 sb at 0x2003, rt=0x12345678 -> data_address=0x2000, byteenable=1000, writedata=0x78787878, data_write high for 1 cycle.
REQ-044 sh at 0x2001 -> align_err pulses, no strobe, stall stays 0; lwl (size 11) at 0x2001 -> normal read, load_addr_lo=1.
REQ-045 lw with waitrequest held 3 cycles -> address and strobe stable across those cycles, load_valid 5 cycles after acceptance.
REQ-046 TIMEOUT=4, waitrequest stuck at 1 -> bus_timeout pulse, no load_valid, FSM back in IDLE.
REQ-047 reset=0 during ACCESS -> strobes 0 at the next edge, IDLE, all outputs at reset values.
